// File: rtl/test_status_monitor_pkg.sv
// Shared definitions for the test status monitor: FSM encoding, default
// tohost address, abort code and a saturating counter helper.
package test_status_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PASS  = 2'd1,
    ST_FAIL  = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

  localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;
  localparam logic [30:0] ABORT_CODE          = 31'h7FFF_FFFF;
  localparam logic [31:0] CNT_MAX             = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pc_hang_detector.sv
// Flags a hang once the fetch pc has presented the same value for
// HANG_CYCLES consecutive cycles (HANG_CYCLES >= 2).
module pc_hang_detector #(
  parameter int HANG_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_pc,
  output logic        o_hang
);

  localparam int            CW        = $clog2(HANG_CYCLES + 1);
  localparam logic [CW-1:0] HIT_AT    = CW'(HANG_CYCLES - 2);
  localparam logic [CW-1:0] MATCH_MAX = CW'(HANG_CYCLES - 1);

  logic [31:0]   r_prev_pc;
  logic [CW-1:0] r_match;
  logic          w_same;

  // An unknown pc is never treated as a repeat, so it can't fake a hang.
  assign w_same = !$isunknown(i_pc) && (i_pc == r_prev_pc);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_pc <= 32'd0;
      r_match   <= '0;
    end else begin
      r_prev_pc <= i_pc;
      if (!w_same)
        r_match <= '0;
      else if (r_match != MATCH_MAX)
        r_match <= r_match + CW'(1);
    end
  end

  // r_match counts repeats before this cycle; the held run length is r_match+2.
  assign o_hang = w_same && (r_match >= HIT_AT);

endmodule

// File: rtl/test_status_monitor.sv
// Watches CPU tohost writes and pc progress, and reports pass / fail /
// timeout / hang through a small memory-mapped status window.
module test_status_monitor
  import test_status_monitor_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = DEFAULT_TOHOST_ADDR,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          HANG_CYCLES    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wen,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  input  logic [31:0] pc,
  output logic        done,
  output logic        pass,
  output logic [30:0] fail_code,
  output logic [31:0] cycle_count,
  output logic [1:0]  state
);

  state_e      r_state;
  state_e      w_next_state;
  logic [31:0] r_tohost;
  logic [31:0] r_cycle_count;
  logic [30:0] r_fail_code;
  logic        w_run;
  logic        w_done;
  logic        w_hang;
  logic        w_tohost_wr;
  logic        w_pass_wr;
  logic        w_fail_wr;
  logic        w_timeout;

  assign w_run       = (r_state == ST_RUN);
  assign w_done      = !w_run;
  assign w_tohost_wr = wen && (addr == TOHOST_ADDR);
  assign w_pass_wr   = w_tohost_wr && (write_data == 32'd1);
  assign w_fail_wr   = w_tohost_wr && write_data[0] && (write_data != 32'd1);
  assign w_timeout   = (r_cycle_count == 32'(TIMEOUT_CYCLES - 1));

  pc_hang_detector #(
    .HANG_CYCLES(HANG_CYCLES)
  ) u_hang (
    .clk   (clk),
    .reset (reset),
    .i_pc  (pc),
    .o_hang(w_hang)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_next_state;
  end

  // Tohost verdict beats timeout, which beats hang.
  always_comb begin
    w_next_state = r_state;
    if (w_run) begin
      if (w_pass_wr)                w_next_state = ST_PASS;
      else if (w_fail_wr)           w_next_state = ST_FAIL;
      else if (w_timeout || w_hang) w_next_state = ST_ABORT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tohost      <= 32'd0;
      r_cycle_count <= 32'd0;
      r_fail_code   <= 31'd0;
    end else if (w_run) begin
      r_cycle_count <= sat_inc(r_cycle_count);
      if (w_tohost_wr)
        r_tohost <= write_data;
      if (w_pass_wr)
        r_fail_code <= r_fail_code;
      else if (w_fail_wr)
        r_fail_code <= write_data[31:1];
      else if (w_timeout || w_hang)
        r_fail_code <= ABORT_CODE;
    end
  end

  always_comb begin
    done        = w_done;
    pass        = (r_state == ST_PASS);
    state       = r_state;
    fail_code   = r_fail_code;
    cycle_count = r_cycle_count;
    if (addr == TOHOST_ADDR)
      read_data = r_tohost;
    else if (addr == TOHOST_ADDR + 32'd4)
      read_data = r_cycle_count;
    else if (addr == TOHOST_ADDR + 32'd8)
      read_data = {29'd0, w_done, r_state};
    else
      read_data = 32'd0;
  end

endmodule
